perf_ctr_ctrl: RTL and testbench

- Programmable hardware performance-monitor controller next to the fixed-function CSR counter file.
- Owns N_CTR 64-bit event counters (mhpmcounter3..), their event selectors (mhpmevent3..) and an inhibit mask (mcountinhibit).
- Sequences CSR read/write/set/clear requests from the execute stage through a request/response handshake.
- Each counter counts one event chosen from a per-cycle event vector: inst_ret, branch_miss, i_hit, i_miss, d_hit, d_miss, and spares.

---
 rtl/perf_ctr_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_perf_ctr_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_ctr_ctrl.sv
// Programmable performance-counter controller: N_CTR 64-bit event counters with selectors and an inhibit mask behind a CSR request/response handshake.
// Optional feature macro PERF_OVF_IRQ_EN adds sticky overflow bits at 0x7C0 and drives ovf_irq.
module perf_ctr_ctrl #(
    parameter int N_CTR   = 4,
    parameter int NUM_EVT = 8,
    parameter int SEL_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [11:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [31:0]        resp_rdata,
    output logic               resp_err,
    output logic               ovf_irq
);
    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [11:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [63:0]      cnt_q [N_CTR];
    logic [63:0]      cnt_d [N_CTR];
    logic [SEL_W-1:0] sel_q [N_CTR];
    logic [SEL_W-1:0] sel_d [N_CTR];
    logic [N_CTR-1:0] inh_q, inh_d;
    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;

    logic [N_CTR-1:0] lo_hit, hi_hit, sel_hit, inc;
    logic             inh_hit, mapped, wr_en;
    logic [31:0]      old_val, new_val, inh_word;

    genvar gi;
    generate
        for (gi = 0; gi < N_CTR; gi++) begin : g_ctr
            logic evt_sel;
            // Selector value k+1 picks evt[k]; 0 and out-of-range values never count.
            always_comb begin
                evt_sel = 1'b0;
                for (int k = 0; k < NUM_EVT; k++) begin
                    if (sel_q[gi] == SEL_W'(k + 1) && evt[k]) begin
                        evt_sel = 1'b1;
                    end
                end
            end
            assign inc[gi]     = evt_sel && !inh_q[gi];
            assign lo_hit[gi]  = (addr_q == 12'(12'hB03 + gi));
            assign hi_hit[gi]  = (addr_q == 12'(12'hB83 + gi));
            assign sel_hit[gi] = (addr_q == 12'(12'h323 + gi));
        end
    endgenerate

    assign inh_hit = (addr_q == 12'h320);

    always_comb begin
        inh_word = '0;
        for (int i = 0; i < N_CTR; i++) begin
            inh_word[3+i] = inh_q[i];
        end
    end

`ifdef PERF_OVF_IRQ_EN
    logic [N_CTR-1:0] ovf_q, ovf_d;
    logic             ovf_irq_q, ovf_irq_d;
    logic             ovf_hit;
    logic [31:0]      ovf_word;

    assign ovf_hit = (addr_q == 12'h7C0);

    always_comb begin
        ovf_word = '0;
        for (int i = 0; i < N_CTR; i++) begin
            ovf_word[3+i] = ovf_q[i];
        end
    end
`endif

    // Old value of the addressed CSR; unmapped addresses read as zero.
    always_comb begin
        old_val = '0;
        mapped  = 1'b0;
        if (inh_hit) begin
            old_val = inh_word;
            mapped  = 1'b1;
        end
`ifdef PERF_OVF_IRQ_EN
        if (ovf_hit) begin
            old_val = ovf_word;
            mapped  = 1'b1;
        end
`endif
        for (int i = 0; i < N_CTR; i++) begin
            if (lo_hit[i]) begin
                old_val = cnt_q[i][31:0];
                mapped  = 1'b1;
            end
            if (hi_hit[i]) begin
                old_val = cnt_q[i][63:32];
                mapped  = 1'b1;
            end
            if (sel_hit[i]) begin
                old_val = 32'(sel_q[i]);
                mapped  = 1'b1;
            end
        end
    end

    always_comb begin
        case (op_q)
            OP_WRITE: new_val = wdata_q;
            OP_SET:   new_val = old_val | wdata_q;
            default:  new_val = old_val & ~wdata_q;
        endcase
    end

    assign wr_en = (state_q == ST_EXEC) && mapped && (op_q != OP_READ);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        inh_d        = inh_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        for (int i = 0; i < N_CTR; i++) begin
            if (inc[i]) begin
                cnt_d[i] = cnt_q[i] + 64'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                resp_rdata_d = old_val;
                resp_err_d   = !mapped;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A half write overrides the whole counter's increment in the commit cycle.
        if (wr_en) begin
            for (int i = 0; i < N_CTR; i++) begin
                if (lo_hit[i]) cnt_d[i] = {cnt_q[i][63:32], new_val};
                if (hi_hit[i]) cnt_d[i] = {new_val, cnt_q[i][31:0]};
                if (sel_hit[i]) sel_d[i] = new_val[SEL_W-1:0];
                if (inh_hit) inh_d[i] = new_val[3+i];
            end
        end

        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
    end

`ifdef PERF_OVF_IRQ_EN
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < N_CTR; i++) begin
            if (wr_en && ovf_hit) ovf_d[i] = new_val[3+i];
            // A half write can never turn an all-ones counter into zero, so this only fires on a wrapping increment.
            if (inc[i] && (&cnt_q[i]) && (cnt_d[i] == '0)) ovf_d[i] = 1'b1;
        end
        ovf_irq_d = |ovf_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q     <= '0;
            ovf_irq_q <= 1'b0;
        end else begin
            ovf_q     <= ovf_d;
            ovf_irq_q <= ovf_irq_d;
        end
    end

    assign ovf_irq = ovf_irq_q;
`else
    assign ovf_irq = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            inh_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            for (int i = 0; i < N_CTR; i++) begin
                cnt_q[i] <= '0;
                sel_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            inh_q        <= inh_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_perf_ctr_ctrl.sv
// Self-checking bench for perf_ctr_ctrl: directed steps plus randomized CSR traffic against a behavioural counter model.
module tb_perf_ctr_ctrl;
    localparam int N  = 4;
    localparam int NE = 8;
`ifdef PERF_OVF_IRQ_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif
    localparam logic [1:0] RD = 2'd0, WR = 2'd1, ST = 2'd2, CL = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  evt = '0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = '0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b0;
    logic        req_ready, resp_valid, resp_err, ovf_irq;
    logic [31:0] resp_rdata;

    int total = 0;
    int bad   = 0;

    logic [63:0]  m_cnt [N];
    logic [7:0]   m_sel [N];
    logic [N-1:0] m_inh, m_ovf;

    perf_ctr_ctrl dut (
        .clk(clk), .rst(rst), .evt(evt),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .ovf_irq(ovf_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = '0;
            m_sel[i] = '0;
        end
        m_inh = '0;
        m_ovf = '0;
    endfunction

    function automatic bit m_read(input logic [11:0] a, output logic [31:0] v);
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(a) == 'hB03 + i) begin v = m_cnt[i][31:0]; return 1'b1; end
            if (int'(a) == 'hB83 + i) begin v = m_cnt[i][63:32]; return 1'b1; end
            if (int'(a) == 'h323 + i) begin v = {24'h0, m_sel[i]}; return 1'b1; end
        end
        if (a == 12'h320) begin
            for (int i = 0; i < N; i++) v[3+i] = m_inh[i];
            return 1'b1;
        end
        if (OVF && a == 12'h7C0) begin
            for (int i = 0; i < N; i++) v[3+i] = m_ovf[i];
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Applies a committed write; returns the counter index it hit, or -1.
    function automatic int m_write(input logic [11:0] a, input logic [31:0] v);
        for (int i = 0; i < N; i++) begin
            if (int'(a) == 'hB03 + i) begin m_cnt[i][31:0] = v; return i; end
            if (int'(a) == 'hB83 + i) begin m_cnt[i][63:32] = v; return i; end
            if (int'(a) == 'h323 + i) begin m_sel[i] = v[7:0]; return -1; end
        end
        if (a == 12'h320) for (int i = 0; i < N; i++) m_inh[i] = v[3+i];
        if (OVF && a == 12'h7C0) for (int i = 0; i < N; i++) m_ovf[i] = v[3+i];
        return -1;
    endfunction

    // One clock: count events with the pre-edge configuration, apply an optional commit, then step.
    task automatic tick(input bit do_wr, input logic [11:0] wa, input logic [31:0] wv);
        bit inc [N];
        int w;
        int s;
        for (int i = 0; i < N; i++) begin
            s = int'(m_sel[i]);
            inc[i] = !m_inh[i] && s >= 1 && s <= NE && evt[s-1];
        end
        w = do_wr ? m_write(wa, wv) : -1;
        for (int i = 0; i < N; i++) begin
            if (inc[i] && i != w) begin
                if (OVF && m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) m_ovf[i] = 1'b1;
                m_cnt[i] = m_cnt[i] + 64'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                       input int hold, input bit stray, input bit rnd, input logic [7:0] exec_evt,
                       output logic [31:0] rd);
        logic [31:0] old_v, new_v, exp_rd;
        bit mapped;
        int n;
        check("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        evt = rnd ? 8'($urandom) : 8'h00;
        tick(1'b0, '0, '0);
        req_valid = 1'b0;
        check("req_ready_exec", req_ready, 1'b0);
        mapped = m_read(a, old_v);
        case (op)
            WR:      new_v = wd;
            ST:      new_v = old_v | wd;
            default: new_v = old_v & ~wd;
        endcase
        evt = rnd ? 8'($urandom) : exec_evt;
        tick(mapped && op != RD, a, new_v);
        evt = rnd ? 8'($urandom) : 8'h00;
        n = 0;
        while (resp_valid !== 1'b1 && n < 8) begin
            tick(1'b0, '0, '0);
            n++;
        end
        check("resp_latency", n, 0);
        exp_rd = mapped ? old_v : 32'h0;
        rd = resp_rdata;
        $display("txn op=%0d addr=0x%03h wdata=0x%08h rdata=0x%08h err=%0b", op, a, wd, resp_rdata, resp_err);
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_err", resp_err, !mapped);
        for (int h = 0; h < hold; h++) begin
            if (stray) begin
                req_valid = 1'b1;
                req_op    = WR;
                req_addr  = 12'h323;
                req_wdata = 32'h7;
            end
            if (rnd) evt = 8'($urandom);
            tick(1'b0, '0, '0);
            check("hold_valid", resp_valid, 1'b1);
            check("hold_req_ready", req_ready, 1'b0);
            check("hold_rdata", resp_rdata, exp_rd);
            check("hold_err", resp_err, !mapped);
        end
        resp_ready = 1'b1;
        if (rnd) evt = 8'($urandom);
        tick(1'b0, '0, '0);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        evt = 8'h00;
        check("resp_done", resp_valid, 1'b0);
        check("idle_ready", req_ready, 1'b1);
        check("ovf_irq", ovf_irq, |m_ovf);
    endtask

    initial begin
        logic [31:0] rd;
        logic [11:0] a;
        logic [31:0] wd;
        int kind;
        int ci;

        m_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_ovf_irq", ovf_irq, 1'b0);
        rst = 1'b0;

        // Counter 0 counts evt[0] for 10 cycles.
        csr(WR, 12'h323, 32'h1, 0, 1'b0, 1'b0, 8'h00, rd);
        evt = 8'h01;
        repeat (10) tick(1'b0, '0, '0);
        evt = 8'h00;
        csr(RD, 12'hB03, 32'h0, 0, 1'b0, 1'b0, 8'h00, rd);
        check("tp1_count10", rd, 32'd10);

        // Inhibit honoured.
        csr(WR, 12'hB03, 32'h0, 0, 1'b0, 1'b0, 8'h00, rd);
        csr(WR, 12'hB83, 32'h0, 0, 1'b0, 1'b0, 8'h00, rd);
        csr(ST, 12'h320, 32'h8, 0, 1'b0, 1'b0, 8'h00, rd);
        evt = 8'h01;
        repeat (5) tick(1'b0, '0, '0);
        evt = 8'h00;
        csr(CL, 12'h320, 32'h8, 0, 1'b0, 1'b0, 8'h00, rd);
        check("tp2_inh_old", rd, 32'h8);
        evt = 8'h01;
        repeat (3) tick(1'b0, '0, '0);
        evt = 8'h00;
        csr(RD, 12'hB03, 32'h0, 0, 1'b0, 1'b0, 8'h00, rd);
        check("tp2_inhibit", rd, 32'd3);

        // 64-bit wrap.
        csr(WR, 12'hB03, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 8'h00, rd);
        csr(WR, 12'hB83, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 8'h00, rd);
        evt = 8'h01;
        tick(1'b0, '0, '0);
        evt = 8'h00;
        csr(RD, 12'hB03, 32'h0, 0, 1'b0, 1'b0, 8'h00, rd);
        check("tp3_wrap_lo", rd, 32'h0);
        csr(RD, 12'hB83, 32'h0, 0, 1'b0, 1'b0, 8'h00, rd);
        check("tp3_wrap_hi", rd, 32'h0);
`ifdef PERF_OVF_IRQ_EN
        check("tp3_ovf_irq", ovf_irq, 1'b1);
        csr(RD, 12'h7C0, 32'h0, 0, 1'b0, 1'b0, 8'h00, rd);
        check("tp3_ovf_bits", rd, 32'h8);
        csr(CL, 12'h7C0, 32'h8, 0, 1'b0, 1'b0, 8'h00, rd);
        check("tp3_ovf_cleared", ovf_irq, 1'b0);
`else
        check("tp3_no_irq", ovf_irq, 1'b0);
        csr(RD, 12'h7C0, 32'h0, 0, 1'b0, 1'b0, 8'h00, rd);
        check("tp3_7c0_unmapped", rd, 32'h0);
`endif

        // Write wins over an increment in the commit cycle.
        csr(WR, 12'h324, 32'h2, 0, 1'b0, 1'b0, 8'h00, rd);
        evt = 8'h02;
        repeat (4) tick(1'b0, '0, '0);
        evt = 8'h00;
        csr(WR, 12'hB04, 32'd100, 0, 1'b0, 1'b0, 8'h02, rd);
        check("tp4_old", rd, 32'd4);
        csr(RD, 12'hB04, 32'h0, 0, 1'b0, 1'b0, 8'h00, rd);
        check("tp4_write_wins", rd, 32'd100);

        // Unmapped read, response held with a competing request pending.
        csr(RD, 12'h123, 32'h0, 4, 1'b1, 1'b0, 8'h00, rd);
        check("tp5_unmapped_rdata", rd, 32'h0);
        csr(RD, 12'h323, 32'h0, 0, 1'b0, 1'b0, 8'h00, rd);
        check("tp5_no_stray_write", rd, 32'h1);

        // Reset during EXEC drops the write.
        check("tp6_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = WR;
        req_addr  = 12'h323;
        req_wdata = 32'h5;
        tick(1'b0, '0, '0);
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_reset();
        check("tp6_resp_valid", resp_valid, 1'b0);
        check("tp6_req_ready", req_ready, 1'b1);
        rst = 1'b0;
        csr(RD, 12'h323, 32'h0, 0, 1'b0, 1'b0, 8'h00, rd);
        check("tp6_sel_dropped", rd, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < N; i++) begin
            csr(WR, 12'(12'h323 + i), 32'($urandom_range(0, 10)), 0, 1'b0, 1'b1, 8'h00, rd);
        end
        csr(WR, 12'h320, $urandom, 0, 1'b0, 1'b1, 8'h00, rd);
        for (int t = 0; t < 70; t++) begin
            kind = $urandom_range(0, 9);
            ci   = $urandom_range(0, N - 1);
            wd   = $urandom;
            case (kind)
                0, 1, 2: a = 12'(12'hB03 + ci);
                3, 4:    a = 12'(12'hB83 + ci);
                5: begin
                    a  = 12'(12'h323 + ci);
                    wd = 32'($urandom_range(0, 10));
                end
                6:       a = 12'h320;
                7:       a = 12'h7C0;
                8:       a = 12'(12'hB03 + N);
                default: a = 12'h123;
            endcase
            csr(2'($urandom_range(0, 3)), a, wd, $urandom_range(0, 2), 1'b0, 1'b1, 8'h00, rd);
            repeat ($urandom_range(0, 3)) begin
                evt = 8'($urandom);
                tick(1'b0, '0, '0);
            end
            evt = 8'h00;
        end
        for (int i = 0; i < N; i++) begin
            csr(RD, 12'(12'hB03 + i), 32'h0, 0, 1'b0, 1'b0, 8'h00, rd);
            csr(RD, 12'(12'hB83 + i), 32'h0, 0, 1'b0, 1'b0, 8'h00, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
